// File: rtl/prio_req_dispatcher_if.sv
// Handshake/bus bundle for prio_req_dispatcher.
//   req_in, mask       : request lines and per-line dispatch enable (driven by master)
//   out_valid, out_idx : offered grant index (driven by slave / dispatcher)
//   out_ready          : downstream accept (driven by master)
//   pending, overflow  : status outputs of the dispatcher
interface prio_req_dispatcher_if #(
  parameter int N_REQ = 8,
  parameter int IDX_W = 3
);
  logic [N_REQ-1:0] req_in;
  logic [N_REQ-1:0] mask;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [N_REQ-1:0] pending;
  logic             overflow;

  modport master (
    output req_in, mask, out_ready,
    input  out_valid, out_idx, pending, overflow
  );

  modport slave (
    input  req_in, mask, out_ready,
    output out_valid, out_idx, pending, overflow
  );
endinterface

// File: rtl/prio_req_dispatcher.sv
// prio_req_dispatcher: captures request events into a sticky pending register
// and offers the highest-numbered pending & enabled index over valid/ready.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : prio_req_dispatcher_if.slave (req_in, mask, out_ready in;
//              out_valid, out_idx, pending, overflow out)

// Per-line capture: edge/level detect, sticky pending bit, overflow term.
module prio_req_lane #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic armed,
  input  logic req,
  input  logic clr,
  output logic pend,
  output logic ovf
);
  logic req_q;
  logic set;

  // Until armed, lines already high when reset is released are not events.
  assign set = EDGE_MODE ? (req & ~req_q & armed) : req;
  assign ovf = EDGE_MODE ? (set & pend & ~clr) : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      req_q <= req;
      pend  <= (pend & ~clr) | set;  // set wins: bit re-arms
    end
  end
endmodule

module prio_req_dispatcher #(
  parameter int N_REQ     = 8,
  parameter int IDX_W     = 3,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  prio_req_dispatcher_if.slave bus
);
  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state;
  logic             armed;
  logic             hs;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] pend_w;
  logic [N_REQ-1:0] ovf_w;
  logic [N_REQ-1:0] pm;
  logic [IDX_W-1:0] hi_idx;

  assign hs = bus.out_valid & bus.out_ready;
  assign pm = pend_w & bus.mask;
  assign bus.pending = pend_w;

  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
      assign clr[g] = hs && (bus.out_idx == IDX_W'(g));
      prio_req_lane #(.EDGE_MODE(EDGE_MODE)) u_lane (
        .clk   (clk),
        .rst   (rst),
        .armed (armed),
        .req   (bus.req_in[g]),
        .clr   (clr[g]),
        .pend  (pend_w[g]),
        .ovf   (ovf_w[g])
      );
    end
  endgenerate

  // Highest set index wins: later iterations overwrite lower ones.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pm[i]) hi_idx = IDX_W'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed        <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      armed        <= 1'b1;
      bus.overflow <= EDGE_MODE ? |ovf_w : 1'b0;
    end
  end

  // Offer is latched and held until accepted; no preemption in OFFER.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
    end else begin
      case (state)
        IDLE: if (|pm) begin
          bus.out_idx   <= hi_idx;
          bus.out_valid <= 1'b1;
          state         <= OFFER;
        end
        OFFER: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prio_req_dispatcher.sv
module tb_prio_req_dispatcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  prio_req_dispatcher_if #(.N_REQ(8), .IDX_W(3)) bus ();
  prio_req_dispatcher #(.N_REQ(8), .IDX_W(3), .EDGE_MODE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       rdy;
    logic       e_vld;
    logic [2:0] e_idx;
    logic [7:0] e_pend;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[14];

  // reference model state
  logic [7:0] m_pend, m_prev;
  logic       m_vld, m_ovf, m_armed;
  logic [2:0] m_idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_st(string tag, logic v, logic [2:0] idx, logic [7:0] pend, logic ovf);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".pending"}, 32'(bus.pending), 32'(pend));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(ovf));
    if (v) chk({tag, ".idx"}, 32'(bus.out_idx), 32'(idx));
  endtask

  // One clock of the dispatch rules, evaluated on inputs present before the edge.
  task automatic model_step();
    logic [7:0] np, pm;
    logic hs, ev, cl;
    hs = m_vld && bus.out_ready;
    np = '0;
    m_ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ev = m_armed && bus.req_in[i] && !m_prev[i];
      cl = hs && (int'(m_idx) == i);
      if (ev && m_pend[i] && !cl) m_ovf = 1'b1;
      np[i] = (m_pend[i] && !cl) || ev;
    end
    pm = m_pend & bus.mask;
    if (m_vld) begin
      if (bus.out_ready) m_vld = 1'b0;
    end else if (pm != 0) begin
      for (int i = 7; i >= 0; i--)
        if (pm[i]) begin m_idx = 3'(i); break; end
      m_vld = 1'b1;
    end
    m_pend  = np;
    m_prev  = bus.req_in;
    m_armed = 1'b1;
  endtask

  initial begin
    logic [7:0] tgl;
    // test 2 then test 3
    tbl[0]  = '{8'h04, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h04, 1'b0};
    tbl[1]  = '{8'h04, 8'hFF, 1'b1, 1'b1, 3'd2, 8'h04, 1'b0};
    tbl[2]  = '{8'h04, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[3]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[4]  = '{8'hAA, 8'hFF, 1'b1, 1'b0, 3'd0, 8'hAA, 1'b0};
    tbl[5]  = '{8'hAA, 8'hFF, 1'b1, 1'b1, 3'd7, 8'hAA, 1'b0};
    tbl[6]  = '{8'hAA, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h2A, 1'b0};
    tbl[7]  = '{8'hAA, 8'hFF, 1'b1, 1'b1, 3'd5, 8'h2A, 1'b0};
    tbl[8]  = '{8'hAA, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h0A, 1'b0};
    tbl[9]  = '{8'hAA, 8'hFF, 1'b1, 1'b1, 3'd3, 8'h0A, 1'b0};
    tbl[10] = '{8'hAA, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h02, 1'b0};
    tbl[11] = '{8'hAA, 8'hFF, 1'b1, 1'b1, 3'd1, 8'h02, 1'b0};
    tbl[12] = '{8'hAA, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[13] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};

    // test 1: reset with all lines high
    rst = 1'b1;
    bus.req_in = 8'hFF; bus.mask = 8'hFF; bus.out_ready = 1'b1;
    #1;
    expect_st("rst", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("rst.idx", 32'(bus.out_idx), 32'd0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_st("rst_rel", 1'b0, 3'd0, 8'h00, 1'b0);
    end
    bus.req_in = 8'h00;
    tick(); tick();

    // tests 2, 3
    for (int i = 0; i < 14; i++) begin
      bus.req_in = tbl[i].req; bus.mask = tbl[i].mask; bus.out_ready = tbl[i].rdy;
      tick();
      expect_st($sformatf("tbl%0d", i), tbl[i].e_vld, tbl[i].e_idx, tbl[i].e_pend, tbl[i].e_ovf);
    end

    // test 4: backpressure, no preemption
    bus.out_ready = 1'b0; bus.req_in = 8'h40;
    tick(); expect_st("bp.cap", 1'b0, 3'd0, 8'h40, 1'b0);
    tick(); expect_st("bp.off", 1'b1, 3'd6, 8'h40, 1'b0);
    bus.req_in = 8'hC0;
    tick(); expect_st("bp.hi", 1'b1, 3'd6, 8'hC0, 1'b0);
    tick(); expect_st("bp.hold", 1'b1, 3'd6, 8'hC0, 1'b0);
    bus.out_ready = 1'b1;
    tick(); expect_st("bp.acc6", 1'b0, 3'd0, 8'h80, 1'b0);
    tick(); expect_st("bp.off7", 1'b1, 3'd7, 8'h80, 1'b0);
    tick(); expect_st("bp.acc7", 1'b0, 3'd0, 8'h00, 1'b0);
    bus.req_in = 8'h00; tick();

    // test 5: masked bit held, dispatched after unmask
    bus.mask = 8'h7F; bus.req_in = 8'h81;
    tick(); expect_st("mk.cap", 1'b0, 3'd0, 8'h81, 1'b0);
    tick(); expect_st("mk.off0", 1'b1, 3'd0, 8'h81, 1'b0);
    tick(); expect_st("mk.acc0", 1'b0, 3'd0, 8'h80, 1'b0);
    tick(); expect_st("mk.held", 1'b0, 3'd0, 8'h80, 1'b0);
    bus.mask = 8'hFF;
    tick(); expect_st("mk.off7", 1'b1, 3'd7, 8'h80, 1'b0);
    tick(); expect_st("mk.acc7", 1'b0, 3'd0, 8'h00, 1'b0);
    bus.req_in = 8'h00; tick();

    // test 6: overflow pulse
    bus.out_ready = 1'b0; bus.req_in = 8'h10;
    tick(); expect_st("ov.cap", 1'b0, 3'd0, 8'h10, 1'b0);
    tick(); expect_st("ov.off", 1'b1, 3'd4, 8'h10, 1'b0);
    bus.req_in = 8'h00;
    tick(); expect_st("ov.fall", 1'b1, 3'd4, 8'h10, 1'b0);
    bus.req_in = 8'h10;
    tick(); expect_st("ov.pulse", 1'b1, 3'd4, 8'h10, 1'b1);
    tick(); expect_st("ov.end", 1'b1, 3'd4, 8'h10, 1'b0);
    bus.out_ready = 1'b1;
    tick(); expect_st("ov.acc", 1'b0, 3'd0, 8'h00, 1'b0);
    bus.req_in = 8'h00;
    tick(); expect_st("ov.single", 1'b0, 3'd0, 8'h00, 1'b0);
    tick(); expect_st("ov.single2", 1'b0, 3'd0, 8'h00, 1'b0);

    // random phase, opened by an asynchronous reset landing mid-offer
    bus.out_ready = 1'b0; bus.req_in = 8'h20;
    tick(); tick();
    #2 rst = 1'b1;
    #1 expect_st("rnd.rst", 1'b0, 3'd0, 8'h00, 1'b0);
    m_pend = '0; m_prev = '0; m_vld = 1'b0; m_ovf = 1'b0; m_idx = '0; m_armed = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tgl = 8'($urandom & $urandom);
      bus.req_in = bus.req_in ^ tgl;
      bus.mask = ($urandom_range(0, 3) != 0) ? 8'hFF : 8'($urandom);
      bus.out_ready = (c % 64 < 12) ? 1'b0 : ($urandom_range(0, 3) != 0);
      model_step();
      tick();
      expect_st($sformatf("rnd%0d", c), m_vld, m_idx, m_pend, m_ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
